wide_add_seq: RTL

Multi-cycle sequencer that drives one shared `n_adder` instance, the N-bit ripple adder with ports A, B, ci, S and co, to add or subtract two W-word operands, one word per cycle, least-significant word first. Carry is chained between words in a register. The block gives software-visible and datapath clients a wide adder/subtractor without a wide combinational carry chain. Handshake is start/done with a busy flag.

---
 rtl/wide_add_seq_if.sv | 27 ++
 rtl/wide_add_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/wide_add_seq_if.sv
// Handshake and operand/result bundle for the word-serial wide adder/subtractor.
// The master drives requests and operands; the slave (wide_add_seq) returns the result.
interface wide_add_seq_if #(
   parameter int N = 8,
   parameter int W = 4
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [N*W-1:0]   a;
   logic [N*W-1:0]   b;
   logic [N*W-1:0]   sum;
   logic             cout;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, sub, cin, a, b,
      input  sum, cout, overflow, busy, done
   );

   modport slave (
      input  start, sub, cin, a, b,
      output sum, cout, overflow, busy, done
   );
endinterface

// File: rtl/wide_add_seq.sv
// Word-serial N*W-bit adder/subtractor: one shared N-bit ripple adder is stepped
// over W words, least-significant first, with the carry chained through a register.

module n_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         ci,
   output logic [N-1:0] S,
   output logic         co
);
   logic [N:0] c;

   always_comb begin
      c    = '0;
      S    = '0;
      c[0] = ci;
      for (int i = 0; i < N; i++) begin
         S[i]   = A[i] ^ B[i] ^ c[i];
         c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
      co = c[N];
   end
endmodule

module wide_add_seq #(
   parameter int N = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   wide_add_seq_if.slave bus
);
   // A single-word operand still needs a one-bit index register.
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [N*W-1:0]     a_q, a_d;
   logic [N*W-1:0]     b_q, b_d;
   logic [N*W-1:0]     sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [N-1:0]       add_a;
   logic [N-1:0]       add_b;
   logic [N-1:0]       add_s;
   logic               add_co;

   assign add_a = a_q[idx_q*N +: N];
   assign add_b = b_q[idx_q*N +: N];

   n_adder #(.N(N)) u_adder (
      .A  (add_a),
      .B  (add_b),
      .ci (carry_q),
      .S  (add_s),
      .co (add_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   // Subtraction is folded into the operand latch: b is stored inverted and the
   // initial carry is forced to 1, so the RUN loop only ever adds.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[idx_q*N +: N] = add_s;
            carry_d             = add_co;
            idx_d               = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_co;
               ovf_d   = (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
endmodule
